// File: rtl/spi_ram_tester.sv
// Built-in self-test sequencer for an SPI RAM behind a simple start/busy controller.
// Fills a word range with an arithmetic pattern and/or reads it back, counting mismatches.
module spi_ram_tester #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_STEP   = 4,
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned STOP_ON_ERR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] pat_step,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_start_write,
  output logic              mem_start_read,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  typedef enum logic [3:0] {
    IDLE,
    WR_ISSUE,
    WR_SETTLE,
    WR_WAIT,
    RD_ISSUE,
    RD_SETTLE,
    RD_WAIT,
    CHECK,
    FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(ADDR_STEP);

  state_t            state_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] num_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] step_q;
  logic [DATA_W-1:0] pat_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ERR_W-1:0]  err_q;
  logic [ADDR_W-1:0] ferr_addr_q;
  logic [DATA_W-1:0] ferr_data_q;
  logic              done_q;
  logic              pass_q;
  logic              wr_q;
  logic              rd_q;

  logic              last_word;
  logic              mismatch;
  logic [ERR_W-1:0]  err_d;

  always_comb begin
    last_word = (idx_q == (num_q - 1'b1));
    mismatch  = (rdata_q != pat_q);
    err_d     = (err_q == '1) ? err_q : err_q + 1'b1;
  end

  // done/pass are loaded on the transition into FINISH so the pulse is visible
  // during the FINISH cycle itself, while outputs stay registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      base_q      <= '0;
      num_q       <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      seed_q      <= '0;
      step_q      <= '0;
      pat_q       <= '0;
      rdata_q     <= '0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              op_q        <= op;
              base_q      <= base_addr;
              num_q       <= num_words;
              seed_q      <= seed;
              step_q      <= pat_step;
              addr_q      <= base_addr;
              pat_q       <= seed;
              idx_q       <= '0;
              err_q       <= '0;
              ferr_addr_q <= '0;
              ferr_data_q <= '0;
              pass_q      <= 1'b0;
              if (op == 2'b00 || num_words == '0) begin
                state_q <= FINISH;
                done_q  <= 1'b1;
                pass_q  <= 1'b1;
              end else if (op[0]) begin
                state_q <= WR_ISSUE;
              end else begin
                state_q <= RD_ISSUE;
              end
            end
          end
          WR_ISSUE: begin
            if (!mem_busy) begin
              wr_q    <= 1'b1;
              state_q <= WR_SETTLE;
            end
          end
          WR_SETTLE: state_q <= WR_WAIT;
          WR_WAIT: begin
            if (!mem_busy) begin
              if (!last_word) begin
                addr_q  <= addr_q + STEP_A;
                pat_q   <= pat_q + step_q;
                idx_q   <= idx_q + 1'b1;
                state_q <= WR_ISSUE;
              end else if (op_q == 2'b11) begin
                addr_q  <= base_q;
                pat_q   <= seed_q;
                idx_q   <= '0;
                state_q <= RD_ISSUE;
              end else begin
                state_q <= FINISH;
                done_q  <= 1'b1;
                pass_q  <= (err_q == '0);
              end
            end
          end
          RD_ISSUE: begin
            if (!mem_busy) begin
              rd_q    <= 1'b1;
              state_q <= RD_SETTLE;
            end
          end
          RD_SETTLE: state_q <= RD_WAIT;
          RD_WAIT: begin
            if (!mem_busy) begin
              rdata_q <= mem_rdata;
              state_q <= CHECK;
            end
          end
          CHECK: begin
            if (mismatch) begin
              err_q <= err_d;
              if (err_q == '0) begin
                ferr_addr_q <= addr_q;
                ferr_data_q <= rdata_q;
              end
            end
            if ((mismatch && STOP_ON_ERR != 0) || last_word) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
              pass_q  <= !mismatch && (err_q == '0);
            end else begin
              addr_q  <= addr_q + STEP_A;
              pat_q   <= pat_q + step_q;
              idx_q   <= idx_q + 1'b1;
              state_q <= RD_ISSUE;
            end
          end
          FINISH:  state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign mem_addr        = addr_q;
  assign mem_wdata       = pat_q;
  assign mem_start_write = wr_q;
  assign mem_start_read  = rd_q;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_addr  = ferr_addr_q;
  assign first_err_data  = ferr_data_q;

endmodule

// File: tb/tb_spi_ram_tester.sv
// Bench for spi_ram_tester: three parameterisations share one memory-controller model;
// each run is predicted from the pattern/address rules and compared with the DUT.
module tb_spi_ram_tester;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        abort = 1'b0;
  logic        hold_busy = 1'b0;
  logic [1:0]  op = '0;
  logic [15:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic [31:0] seed = '0;
  logic [31:0] pat_step = '0;
  logic        start_a = 1'b0, start_s = 1'b0, start_e = 1'b0;
  logic        mem_busy;
  logic [31:0] mem_rdata = '0;

  logic [15:0] mem_addr_a, mem_addr_s, mem_addr_e;
  logic [31:0] mem_wdata_a, mem_wdata_s, mem_wdata_e;
  logic        msw_a, msw_s, msw_e, msr_a, msr_s, msr_e;
  logic        busy_a, busy_s, busy_e, done_a, done_s, done_e, pass_a, pass_s, pass_e;
  logic [7:0]  err_a, err_s;
  logic [1:0]  err_e;
  logic [15:0] fea_a, fea_s, fea_e;
  logic [31:0] fed_a, fed_s, fed_e;

  always #5 clk = ~clk;

  spi_ram_tester #(.ADDR_W(16), .DATA_W(32), .ADDR_STEP(4), .ERR_W(8), .STOP_ON_ERR(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .op(op), .base_addr(base_addr),
    .num_words(num_words), .seed(seed), .pat_step(pat_step), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_start_write(msw_a), .mem_start_read(msr_a),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_addr(fea_a), .first_err_data(fed_a));

  spi_ram_tester #(.ADDR_W(16), .DATA_W(32), .ADDR_STEP(4), .ERR_W(8), .STOP_ON_ERR(1)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .abort(abort), .op(op), .base_addr(base_addr),
    .num_words(num_words), .seed(seed), .pat_step(pat_step), .mem_addr(mem_addr_s),
    .mem_wdata(mem_wdata_s), .mem_start_write(msw_s), .mem_start_read(msr_s),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .first_err_addr(fea_s), .first_err_data(fed_s));

  spi_ram_tester #(.ADDR_W(16), .DATA_W(32), .ADDR_STEP(4), .ERR_W(2), .STOP_ON_ERR(0)) dut_e (
    .clk(clk), .rst(rst), .start(start_e), .abort(abort), .op(op), .base_addr(base_addr),
    .num_words(num_words), .seed(seed), .pat_step(pat_step), .mem_addr(mem_addr_e),
    .mem_wdata(mem_wdata_e), .mem_start_write(msw_e), .mem_start_read(msr_e),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .busy(busy_e), .done(done_e), .pass(pass_e),
    .err_count(err_e), .first_err_addr(fea_e), .first_err_data(fed_e));

  // ---------------- memory controller model ----------------
  int unsigned busy_cnt = 0;
  int          wr_cnt = 0, rd_cnt = 0, viol = 0;
  logic        prev_req = 1'b0;
  logic [47:0] wr_log[$];
  logic [31:0] mem_arr [int unsigned];
  bit          corrupt [int unsigned];

  assign mem_busy = (busy_cnt != 0) || hold_busy;

  always @(posedge clk) begin : mem_model
    logic        w, r;
    logic [15:0] a;
    logic [31:0] d;
    w = msw_a | msw_s | msw_e;
    r = msr_a | msr_s | msr_e;
    a = (msw_a | msr_a) ? mem_addr_a : ((msw_s | msr_s) ? mem_addr_s : mem_addr_e);
    d = (msw_a | msr_a) ? mem_wdata_a : ((msw_s | msr_s) ? mem_wdata_s : mem_wdata_e);
    if ((w || r) && (mem_busy || prev_req || (w && r))) viol++;
    prev_req = w || r;
    if (w) begin
      mem_arr[a] = d;
      wr_log.push_back({a, d});
      wr_cnt++;
      busy_cnt <= $urandom_range(4, 1);
    end else if (r) begin
      rd_cnt++;
      mem_rdata <= corrupt.exists(a) ? 32'hDEADBEEF : (mem_arr.exists(a) ? mem_arr[a] : 32'h0);
      busy_cnt <= $urandom_range(4, 1);
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // ---------------- reference model and checking ----------------
  int total = 0, bad = 0;
  logic [31:0] exp_mem [int unsigned];
  logic [47:0] exp_wl[$];
  int          e_rd, e_err;
  logic [15:0] e_fa;
  logic [31:0] e_fd;
  logic        e_pass;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic predict(input logic [1:0] o, input logic [15:0] b, input logic [15:0] n,
                         input logic [31:0] sd, input logic [31:0] st, input bit stop,
                         input int errmax);
    int          nmis;
    logic [15:0] a;
    logic [31:0] d, rv;
    exp_wl.delete();
    e_rd = 0; e_fa = '0; e_fd = '0; nmis = 0;
    if (o != 2'b00 && n != 0) begin
      if (o[0]) begin
        for (int i = 0; i < int'(n); i++) begin
          a = 16'(int'(b) + i * 4);
          d = sd + 32'(i) * st;
          exp_mem[a] = d;
          exp_wl.push_back({a, d});
        end
      end
      if (o[1]) begin
        for (int i = 0; i < int'(n); i++) begin
          a = 16'(int'(b) + i * 4);
          d = sd + 32'(i) * st;
          rv = corrupt.exists(a) ? 32'hDEADBEEF : (exp_mem.exists(a) ? exp_mem[a] : 32'h0);
          e_rd++;
          if (rv != d) begin
            if (nmis == 0) begin e_fa = a; e_fd = rv; end
            nmis++;
            if (stop) break;
          end
        end
      end
    end
    e_err  = (nmis > errmax) ? errmax : nmis;
    e_pass = (nmis == 0);
  endtask

  task automatic run(input int which, input logic [1:0] o, input logic [15:0] b,
                     input logic [15:0] n, input logic [31:0] sd, input logic [31:0] st,
                     input string tag);
    int w0, r0, dn, to;
    logic dv, bv;
    logic [63:0] ev, pv, fav, fdv;
    predict(o, b, n, sd, st, which == 1, (which == 2) ? 3 : 255);
    w0 = wr_cnt; r0 = rd_cnt;
    @(negedge clk);
    op = o; base_addr = b; num_words = n; seed = sd; pat_step = st;
    if (which == 0) start_a = 1'b1; else if (which == 1) start_s = 1'b1; else start_e = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_s = 1'b0; start_e = 1'b0;
    dn = 0; to = 1;
    for (int c = 0; c < 3000; c++) begin
      dv = (which == 0) ? done_a : (which == 1) ? done_s : done_e;
      bv = (which == 0) ? busy_a : (which == 1) ? busy_s : busy_e;
      if (dv) dn++;
      if (!bv) begin to = 0; break; end
      @(negedge clk);
    end
    repeat (3) begin
      @(negedge clk);
      if (((which == 0) ? done_a : (which == 1) ? done_s : done_e)) dn++;
    end
    ev  = (which == 0) ? 64'(err_a) : (which == 1) ? 64'(err_s) : 64'(err_e);
    pv  = (which == 0) ? 64'(pass_a) : (which == 1) ? 64'(pass_s) : 64'(pass_e);
    fav = (which == 0) ? 64'(fea_a) : (which == 1) ? 64'(fea_s) : 64'(fea_e);
    fdv = (which == 0) ? 64'(fed_a) : (which == 1) ? 64'(fed_s) : 64'(fed_e);
    chk({tag, ".timeout"}, 64'(to), 64'd0);
    chk({tag, ".done_cnt"}, 64'(dn), 64'd1);
    chk({tag, ".err"}, ev, 64'(e_err));
    chk({tag, ".pass"}, pv, 64'(e_pass));
    chk({tag, ".first_addr"}, fav, 64'(e_fa));
    chk({tag, ".first_data"}, fdv, 64'(e_fd));
    chk({tag, ".writes"}, 64'(wr_cnt - w0), 64'(exp_wl.size()));
    chk({tag, ".reads"}, 64'(rd_cnt - r0), 64'(e_rd));
    for (int i = 0; i < exp_wl.size(); i++)
      chk({tag, ".wlog"}, 64'((w0 + i < wr_log.size()) ? wr_log[w0 + i] : 48'hFFFF_FFFF_FFFF),
          64'(exp_wl[i]));
  endtask

  initial begin : stim
    logic [1:0]  ro;
    logic [15:0] rb, rn;
    logic [31:0] rs, rt;
    int          w0, to, dn;

    repeat (3) @(negedge clk);
    chk("reset.busy", 64'(busy_a), 64'd0);
    chk("reset.done", 64'(done_a), 64'd0);
    chk("reset.pass", 64'(pass_a), 64'd0);
    chk("reset.mstart", 64'({msw_a, msr_a}), 64'd0);
    chk("reset.err", 64'(err_a), 64'd0);
    chk("reset.first", 64'({fea_a, fed_a}), 64'd0);
    chk("reset.mem", 64'({mem_addr_a, mem_wdata_a}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(0, 2'b11, 16'h0000, 16'd4, 32'd1, 32'd1, "fill_verify");
    chk("fill_verify.w0", 64'(wr_log[0]), 64'({16'h0000, 32'd1}));
    chk("fill_verify.w3", 64'(wr_log[3]), 64'({16'h000C, 32'd4}));

    corrupt[16'h0008] = 1'b1;
    run(0, 2'b10, 16'h0000, 16'd4, 32'd1, 32'd1, "corrupt8");

    corrupt[16'h000C] = 1'b1;
    run(1, 2'b11, 16'h0000, 16'd4, 32'd1, 32'd1, "stop_on_err");

    corrupt.delete();
    for (int i = 0; i < 6; i++) corrupt[32'h0100 + 32'(i * 4)] = 1'b1;
    run(2, 2'b11, 16'h0100, 16'd6, 32'd5, 32'd7, "saturate");

    corrupt.delete();
    run(0, 2'b01, 16'hFFF8, 16'd4, 32'h1234_0000, 32'h0101_0101, "wrap");

    run(0, 2'b00, 16'h0040, 16'd3, 32'd9, 32'd1, "op_none");

    // mem_busy held high: no issue until it falls, then abort mid-wait
    hold_busy = 1'b1;
    w0 = wr_cnt;
    @(negedge clk);
    op = 2'b01; base_addr = 16'h8000; num_words = 16'd2; seed = 32'hCAFE_0001; pat_step = 32'd1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (50) @(negedge clk);
    chk("hold.no_issue", 64'(wr_cnt - w0), 64'd0);
    chk("hold.busy", 64'(busy_a), 64'd1);
    hold_busy = 1'b0;
    to = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (wr_cnt != w0) begin to = 0; break; end
    end
    hold_busy = 1'b1;
    chk("hold.issue_timeout", 64'(to), 64'd0);
    chk("hold.wlog", 64'(wr_log[wr_log.size() - 1]), 64'({16'h8000, 32'hCAFE_0001}));
    exp_mem[16'h8000] = 32'hCAFE_0001;
    repeat (3) @(negedge clk);
    chk("abort.busy_before", 64'(busy_a), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    chk("abort.busy", 64'(busy_a), 64'd0);
    chk("abort.done", 64'(done_a), 64'd0);
    abort = 1'b0;
    hold_busy = 1'b0;
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_a || busy_a) dn++;
    end
    chk("abort.stays_idle", 64'(dn), 64'd0);
    chk("abort.pass_frozen", 64'(pass_a), 64'd0);
    chk("abort.writes", 64'(wr_cnt - w0), 64'd1);

    // N=0: done one cycle after start, pass=1
    op = 2'b11; num_words = 16'd0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("n0.done", 64'(done_a), 64'd1);
    chk("n0.pass", 64'(pass_a), 64'd1);
    @(negedge clk);
    chk("n0.done_drop", 64'({done_a, busy_a}), 64'd0);

    for (int k = 0; k < 10; k++) begin
      ro = 2'($urandom_range(3, 1));
      rb = 16'($urandom);
      rn = 16'($urandom_range(8, 1));
      rs = $urandom;
      rt = $urandom;
      corrupt.delete();
      if ($urandom_range(1, 0) == 1)
        corrupt[32'(16'(rb + 16'($urandom_range(int'(rn) - 1, 0)) * 16'd4))] = 1'b1;
      if ($urandom_range(3, 0) == 0) rs = 32'hDEADBEEF;
      run(0, ro, rb, rn, rs, rt, $sformatf("rand%0d", k));
    end

    // reset mid-run drops the request strobe immediately
    corrupt.delete();
    @(negedge clk);
    op = 2'b11; base_addr = 16'h2000; num_words = 16'd8; seed = 32'd3; pat_step = 32'd2;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    to = 1;
    for (int c = 0; c < 200; c++) begin
      if (msw_a) begin to = 0; break; end
      @(negedge clk);
    end
    chk("rst_mid.strobe_seen", 64'(to), 64'd0);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid.strobe", 64'({msw_a, msr_a}), 64'd0);
    chk("rst_mid.busy", 64'(busy_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    w0 = wr_cnt;
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy_a || done_a) dn++;
    end
    chk("rst_mid.idle", 64'(dn), 64'd0);
    chk("rst_mid.no_writes", 64'(wr_cnt - w0), 64'd0);

    chk("protocol.violations", 64'(viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
